// File: rtl/ahb_cmd_master_pkg.sv
// Shared AHB-Lite encodings for the command master and the AHB-to-APB bridge.
// Also holds the master's phase-state encoding: {address phase, data phase}.
package ahb_cmd_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // Bit 1 = address phase driven (A), bit 0 = data phase pending (D)
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DATA      = 2'b01,
    ST_ADDR      = 2'b10,
    ST_ADDR_DATA = 2'b11
  } phase_e;

endpackage

// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator: valid/ready commands in, single NONSEQ transfers out,
// one response pulse per command. Address phase overlaps the previous data phase.
module ahb_cmd_master
  import ahb_cmd_master_pkg::*;
#(
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32
) (
  input  logic                iClk,
  input  logic                iRsn,
  input  logic                iCmdValid,
  output logic                oCmdReady,
  input  logic                iCmdWrite,
  input  logic [P_ADDR_W-1:0] iCmdAddr,
  input  logic [P_DATA_W-1:0] iCmdWdata,
  output logic                oRspValid,
  output logic [P_DATA_W-1:0] oRspRdata,
  output logic                oRspErr,
  output logic                oBusy,
  output logic                oHSEL,
  output logic [P_ADDR_W-1:0] oHADDR,
  output logic [1:0]          oHTRANS,
  output logic                oHWRITE,
  output logic [P_DATA_W-1:0] oHWDATA,
  input  logic                iHREADY,
  input  logic [P_DATA_W-1:0] iHRDATA,
  input  logic [1:0]          iHRESP
);

  phase_e                r_state;
  phase_e                w_state_nxt;
  logic                  w_a;
  logic                  w_d;
  logic                  w_accept;
  logic                  w_addr_ret;
  logic                  w_data_ret;
  logic [P_DATA_W-1:0]   r_wdata_q;
  logic                  r_d_write;

  assign w_a = r_state[1];
  assign w_d = r_state[0];

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An accept re-arms A even when the current address phase retires on the same edge
  always_comb begin
    logic w_a_nxt;
    logic w_d_nxt;
    w_a_nxt     = w_accept | (w_a & ~w_addr_ret);
    w_d_nxt     = w_addr_ret | (w_d & ~w_data_ret);
    w_state_nxt = phase_e'({w_a_nxt, w_d_nxt});
  end

  // oCmdReady is combinational from iHREADY: the held address phase frees on this edge
  always_comb begin
    oCmdReady  = !w_a || iHREADY;
    oBusy      = w_a || w_d;
    w_accept   = iCmdValid && oCmdReady;
    w_addr_ret = w_a && iHREADY;
    w_data_ret = w_d && iHREADY;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oHSEL     <= 1'b0;
      oHADDR    <= '0;
      oHTRANS   <= HTRANS_IDLE;
      oHWRITE   <= 1'b0;
      oHWDATA   <= '0;
      r_wdata_q <= '0;
      r_d_write <= 1'b0;
      oRspValid <= 1'b0;
      oRspRdata <= '0;
      oRspErr   <= 1'b0;
    end else begin
      if (w_accept) begin
        oHSEL     <= 1'b1;
        oHADDR    <= iCmdAddr;
        oHTRANS   <= HTRANS_NONSEQ;
        oHWRITE   <= iCmdWrite;
        r_wdata_q <= iCmdWdata;
      end else if (w_addr_ret) begin
        oHSEL     <= 1'b0;
        oHTRANS   <= HTRANS_IDLE;
      end

      if (w_addr_ret) begin
        r_d_write <= oHWRITE;
        oHWDATA   <= r_wdata_q;
      end

      // Any non-OKAY code (ERROR, RETRY, SPLIT) is reported, never retried
      oRspValid <= w_data_ret;
      if (w_data_ret) begin
        oRspRdata <= r_d_write ? '0 : iHRDATA;
        oRspErr   <= (iHRESP != HRESP_OKAY);
      end
    end
  end

endmodule

// File: doc/ahb_cmd_master.md
# ahb_cmd_master

AHB-Lite initiator that turns a simple valid/ready command stream into single NONSEQ AHB transfers and returns one response per command. It drives the AHB side of the AHB-to-APB bridge, so register accesses to the APB slave come from a command interface rather than a testbench-only master. The address phase of the next transfer overlaps the data phase of the current one, which gives back-to-back throughput of one transfer per HREADY cycle.

## Interface
- P_ADDR_W, 32: AHB address width.
- P_DATA_W, 32: AHB data width.
- iClk  in  1  single clock; all logic is rising-edge.
- iRsn  in  1  reset, asynchronous assert, active-low.
- iCmdValid  in  1  command present.
- oCmdReady  out  1  command accepted on an edge where iCmdValid && oCmdReady.
- iCmdWrite  in  1  1 = write, 0 = read.
- iCmdAddr  in  P_ADDR_W  transfer address.
- iCmdWdata  in  P_DATA_W  write data (ignored for reads).
- oRspValid  out  1  one-cycle response pulse.
- oRspRdata  out  P_DATA_W  read data (0 for writes).
- oRspErr  out  1  the transfer completed with non-OKAY HRESP.
- oBusy  out  1  an address or data phase is outstanding.
- oHSEL  out  1  slave select; high exactly when oHTRANS = NONSEQ.
- oHADDR  out  P_ADDR_W  address-phase address.
- oHTRANS  out  2  IDLE = 2'b00 or NONSEQ = 2'b10 only.
- oHWRITE  out  1  address-phase direction.
- oHWDATA  out  P_DATA_W  data-phase write data.
- iHREADY  in  1  transfer-ready from the slave; system top also feeds it to the bridge's HREADYin.
- iHRDATA  in  P_DATA_W  read data.
- iHRESP  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.

## Operation
- Two phase-valid flags, A (address phase driven) and D (data phase pending), give four states: IDLE (A0 D0), ADDR (A1 D0), DATA (A0 D1), ADDR_DATA (A1 D1).
- oCmdReady = !A || iHREADY. This is combinational from iHREADY, because the current address phase retires on the same edge.
- Accept edge: A<=1. oHADDR, oHWRITE and oHSEL<=1 load, oHTRANS<=NONSEQ, and the write data goes to a holding register rWdataQ.
- Address retire (A && iHREADY): D<=1, rDWrite<=oHWRITE, oHWDATA<=rWdataQ. If no command is accepted on the same edge: A<=0, oHTRANS<=IDLE, oHSEL<=0. oHADDR and oHWRITE hold their last value.
- Data retire (D && iHREADY): oRspValid<=1, oRspRdata<=rDWrite ? 0 : iHRDATA, oRspErr<=(iHRESP != 00). D clears unless an address phase retires on the same edge.
- Address retire, data retire and a new accept can all happen on one edge. All three take effect together, with no bubble.
- Non-OKAY HRESP: no cancel, no retry. A pending address phase proceeds unchanged. RETRY and SPLIT are reported as errors.
- iHREADY low holds every AHB output and all state. oCmdReady is low while A=1.
- oBusy = A || D.

## Timing
- Reset (iRsn low, asynchronous): A=D=0, oHTRANS=00, oHSEL=0, oHADDR=0, oHWRITE=0, oHWDATA=0, oRspValid=0, oRspRdata=0, oRspErr=0, rWdataQ=0.
- Reset mid-transfer abandons the transfer. No response is issued.
- Zero-wait read: accept at edge N, address phase N..N+1, data retire at N+2, oRspValid high in cycle N+2..N+3.
- Latency is 2 cycles plus the wait states. Throughput is 1 response per cycle with continuous iCmdValid and iHREADY=1.
- oRspValid is never high on two consecutive cycles unless two data phases retire on consecutive edges.

## Structure
- Shared package holds the HTRANS codes (IDLE, BUSY, NONSEQ, SEQ) and HRESP codes (OKAY, ERROR, RETRY, SPLIT). The bridge uses the same constants.
- No sub-module: a single module with the phase flags and the datapath registers.
- The system top instantiates ahb_cmd_master and the bridge top.
- At system top, oHREADYout from the bridge feeds both iHREADY and the bridge HREADYin.

## Test plan
- Reset then idle: oHTRANS=00, oHSEL=0, oCmdReady=1, oBusy=0, no oRspValid.
- Write 0x0000_0004 ← 0xDEAD_BEEF with a zero-wait slave:
  - NONSEQ with oHADDR=0x4 and oHWRITE=1 for 1 cycle.
  - oHWDATA=0xDEAD_BEEF in the next cycle.
  - oRspValid with oRspErr=0 two cycles after acceptance.
- Read 0x4 through the bridge/APB slave with 2 wait states: oHADDR held, oCmdReady=0 while the address is stalled, oRspRdata=0xDEAD_BEEF, latency 4 cycles.
- Four back-to-back writes to 0x0, 0x4, 0x8, 0xC with HREADY=1:
  - oHTRANS stays NONSEQ for 4 consecutive cycles.
  - 4 consecutive oRspValid pulses, in order.
- Slave returns HRESP=01 on read 0x100 (cycle 1 HREADY=0, cycle 2 HREADY=1), with a queued write behind it:
  - oRspErr=1 for the read.
  - The queued write still completes with oRspErr=0.
- iRsn pulled low during the data phase of a read stalled by HREADY=0:
  - All outputs go to reset values immediately.
  - No response after reset release.
